// File: rtl/dm_responder.sv
// Data-memory responder: word-organised RAM serving M-stage loads/stores over valid/ready.
// Optional store trace printing is enabled by defining DM_TRACE_EN.

package dm_responder_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dm_state_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } dm_resp_t;
endpackage

module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  logic [31:0]           mem [DEPTH];
  dm_state_t             state, state_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  dm_resp_t              res, res_c;

  logic                  accept_c;
  logic [ADDR_WIDTH-1:0] idx_c;
  logic [31:0]           cur_c;
  logic                  oor_c, illegal_c, misalign_c, err_c;
  logic [31:0]           merged_c, load_c;
  logic [15:0]           half_c;
  logic [7:0]            byte_c;

  assign accept_c  = (state == IDLE) && req_valid && req_ready;
  assign idx_c     = req_addr[ADDR_WIDTH+1:2];
  assign cur_c     = mem[idx_c];
  assign oor_c     = |req_addr[31:ADDR_WIDTH+2];
  assign illegal_c = (req_op > 3'd4);
  assign err_c     = oor_c || illegal_c || misalign_c;

  // Alignment check, lane extraction with extension, and store lane merge
  always_comb begin
    misalign_c = 1'b0;
    merged_c   = cur_c;
    load_c     = '0;
    half_c     = req_addr[1] ? cur_c[31:16] : cur_c[15:0];
    byte_c     = cur_c[{req_addr[1:0], 3'b000} +: 8];
    case (req_op)
      3'd0: begin
        misalign_c = (req_addr[1:0] != 2'b00);
        merged_c   = req_wdata;
        load_c     = cur_c;
      end
      3'd1, 3'd2: begin
        misalign_c = req_addr[0];
        merged_c[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
        load_c     = {{16{req_op[1] & half_c[15]}}, half_c};
      end
      3'd3, 3'd4: begin
        merged_c[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
        load_c     = {{24{req_op[2] & byte_c[7]}}, byte_c};
      end
      default: ;
    endcase
  end

  // Result captured at acceptance; stores and errors never carry data
  always_comb begin
    res_c.err   = err_c;
    res_c.rdata = (err_c || req_write) ? 32'h0 : load_c;
  end

  // RAM: cleared by reset, written only by a clean store at its acceptance edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[ADDR_WIDTH'(i)] <= '0;
      end
    end else if (accept_c && req_write && !err_c) begin
      mem[idx_c] <= merged_c;
    end
  end

  // Next-state and latency counter
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept_c) begin
          cnt_next   = CNT_LOAD;
          state_next = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (resp_valid && resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and registered handshake/response outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      res        <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      req_ready  <= (state_next == IDLE);
      resp_valid <= (state_next == RESP);
      if (accept_c) begin
        res <= res_c;
      end
      if (state_next == RESP) begin
        resp_rdata <= accept_c ? res_c.rdata : res.rdata;
        resp_err   <= accept_c ? res_c.err : res.err;
      end else begin
        resp_rdata <= '0;
        resp_err   <= 1'b0;
      end
    end
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset && accept_c && req_write && !err_c) begin
      $display("%d@%h: *%h <= %h", $time, req_pc, {req_addr[31:2], 2'b00}, merged_c);
    end
  end
`else
  logic unused_pc_c;
  assign unused_pc_c = ^req_pc;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder (ADDR_WIDTH=12, LATENCY=2).
module tb_dm_responder;
  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  dm_responder #(.ADDR_WIDTH(12), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction from an IDLE negedge; hold = cycles of response backpressure
  task automatic xact(input string tag, input logic w, input logic [2:0] op,
                      input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                      input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    chk({tag, " req_ready"}, 32'(req_ready), 32'h1);
    resp_ready = (hold == 0);
    req_valid  = 1'b1;
    req_write  = w;
    req_op     = op;
    req_addr   = addr;
    req_wdata  = wdata;
    req_pc     = 32'h0000_1000 + addr;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(LAT));
    chk({tag, " rdata"}, resp_rdata, exp_rd);
    chk({tag, " err"}, 32'(resp_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold valid/ready"}, 32'({resp_valid, req_ready}), 32'h2);
      chk({tag, " hold rdata"}, resp_rdata, exp_rd);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk({tag, " back to idle"}, 32'({resp_valid, req_ready, resp_err}), 32'h2);
    chk({tag, " rdata cleared"}, resp_rdata, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_op     = 3'd0;
    req_addr   = '0;
    req_wdata  = '0;
    req_pc     = '0;
    resp_ready = 1'b1;

    // Reset held for three cycles
    repeat (3) @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'h0);
    chk("rst resp_valid", 32'(resp_valid), 32'h0);
    chk("rst rdata", resp_rdata, 32'h0);
    chk("rst err", 32'(resp_err), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("post-rst req_ready", 32'(req_ready), 32'h1);
    chk("post-rst resp_valid", 32'(resp_valid), 32'h0);
    chk("post-rst outputs", {resp_rdata[31:1], resp_err}, 32'h0);

    // Word store / load
    xact("sw 0x10",     1'b1, 3'd0, 32'h10, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
    xact("lw 0x10",     1'b0, 3'd0, 32'h10, 32'h0,         0, 32'hDEAD_BEEF, 1'b0);

    // Sub-word stores and extended loads
    xact("sw 0x10 b",   1'b1, 3'd0, 32'h10, 32'h1122_3344, 0, 32'h0, 1'b0);
    xact("sb 0x13",     1'b1, 3'd3, 32'h13, 32'hFFFF_FF80, 0, 32'h0, 1'b0);
    xact("lw merged",   1'b0, 3'd0, 32'h10, 32'h0, 0, 32'h8022_3344, 1'b0);
    xact("lb 0x13",     1'b0, 3'd4, 32'h13, 32'h0, 0, 32'hFFFF_FF80, 1'b0);
    xact("lbu 0x13",    1'b0, 3'd3, 32'h13, 32'h0, 0, 32'h0000_0080, 1'b0);
    xact("lh 0x12",     1'b0, 3'd2, 32'h12, 32'h0, 0, 32'hFFFF_8022, 1'b0);
    xact("lhu 0x12",    1'b0, 3'd1, 32'h12, 32'h0, 0, 32'h0000_8022, 1'b0);
    xact("lbu 0x10",    1'b0, 3'd3, 32'h10, 32'h0, 0, 32'h0000_0044, 1'b0);
    xact("lh 0x10",     1'b0, 3'd2, 32'h10, 32'h0, 0, 32'h0000_3344, 1'b0);
    xact("sh 0x10",     1'b1, 3'd2, 32'h10, 32'h1234_ABCD, 0, 32'h0, 1'b0);
    xact("lw after sh", 1'b0, 3'd0, 32'h10, 32'h0, 0, 32'h8022_ABCD, 1'b0);
    xact("lb 0x11",     1'b0, 3'd4, 32'h11, 32'h0, 0, 32'hFFFF_FFAB, 1'b0);

    // Error responses and their lack of side effects
    xact("lw misalign", 1'b0, 3'd0, 32'h2,    32'h0, 0, 32'h0, 1'b1);
    xact("sw oor",      1'b1, 3'd0, 32'h4000, 32'hFFFF_FFFF, 0, 32'h0, 1'b1);
    xact("lw word0",    1'b0, 3'd0, 32'h0,    32'h0, 0, 32'h0, 1'b0);
    xact("op6 load",    1'b0, 3'd6, 32'h10,   32'h0, 0, 32'h0, 1'b1);
    xact("op5 store",   1'b1, 3'd5, 32'h10,   32'h5555_5555, 0, 32'h0, 1'b1);
    xact("lh misalign", 1'b0, 3'd2, 32'h11,   32'h0, 0, 32'h0, 1'b1);
    xact("lw intact",   1'b0, 3'd0, 32'h10,   32'h0, 0, 32'h8022_ABCD, 1'b0);
    xact("sw top",      1'b1, 3'd0, 32'h3FFC, 32'hCAFE_F00D, 0, 32'h0, 1'b0);
    xact("lw top",      1'b0, 3'd0, 32'h3FFC, 32'h0, 0, 32'hCAFE_F00D, 1'b0);

    // Backpressure, then an immediate follow-on request
    xact("lw bp",       1'b0, 3'd0, 32'h10, 32'h0, 5, 32'h8022_ABCD, 1'b0);
    xact("lw after bp", 1'b0, 3'd0, 32'h3FFC, 32'h0, 0, 32'hCAFE_F00D, 1'b0);

    // Reset asserted while a load is waiting
    chk("mid-rst req_ready", 32'(req_ready), 32'h1);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_op    = 3'd0;
    req_addr  = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid-rst valid/ready", 32'({resp_valid, req_ready}), 32'h0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("mid-rst released", 32'({resp_valid, req_ready}), 32'h1);
    xact("lw after rst",     1'b0, 3'd0, 32'h10,   32'h0, 0, 32'h0, 1'b0);
    xact("lw top after rst", 1'b0, 3'd0, 32'h3FFC, 32'h0, 0, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder serving the M-stage load/store requests of the 5-stage pipeline, over a valid/ready request and response handshake.
- Holds a word-organised RAM and returns load data after a programmable latency.
- Supports word, half and byte accesses with sign or zero extension.
- Flags misaligned, out-of-range and illegal-op accesses with an error response instead of touching memory.

Parameters:
ADDR_WIDTH, 12, word-index width; RAM holds 2**ADDR_WIDTH 32-bit words
LATENCY, 2, cycles from request acceptance to resp_valid; legal range 1..15

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_write  input  1  1 = store, 0 = load
req_op  input  3  0 word, 1 half unsigned, 2 half signed, 3 byte unsigned, 4 byte signed; 5-7 illegal
req_addr  input  32  byte address
req_wdata  input  32  store data; half/byte stores use low 16/8 bits
req_pc  input  32  PC of the requesting instruction (trace only)
resp_valid  output  1  response available
resp_ready  input  1  consumer takes response
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  misaligned, out-of-range or illegal op

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
  - All RAM words are 0.
  - Any pending transaction is discarded.
  - req_ready rises in the first cycle after reset deasserts.
- States and transitions:
  - IDLE -> WAIT on accept, when LATENCY>1.
  - IDLE -> RESP on accept, when LATENCY=1.
  - WAIT -> RESP when the counter reaches 0.
  - RESP -> IDLE on resp_valid && resp_ready.
- IDLE: req_ready=1. A request is accepted on a clock edge with req_valid=1.
- Acceptance edge (cycle T):
  - Decode: word index = req_addr[ADDR_WIDTH+1:2].
  - Error if req_addr[31:ADDR_WIDTH+2]!=0, or req_op>=5, or the access is misaligned (half: addr[0]!=0; word: addr[1:0]!=0).
  - Store without error: write the selected lanes at this edge. Half uses lanes addr[1]; byte uses lane addr[1:0]; other lanes unchanged.
  - Load without error: capture the selected field and extend it (signed ops replicate the top bit).
  - Error: no RAM access; the captured result is rdata=0, err=1.
  - Counter loads LATENCY-1.
- WAIT: req_ready=0; the counter decrements each cycle.
- RESP:
  - resp_valid=1 from cycle T+LATENCY. rdata and err are held stable until the handshake completes.
  - req_ready=0 throughout, so there is never more than one outstanding transaction.
- Maximum throughput: one transaction per LATENCY+1 cycles when resp_ready is held high.
- resp_rdata and resp_err return to 0 when leaving RESP.
- Read-after-write: a load accepted after a store completes observes the new data. There is no internal bypass, because requests are serialised.
- req_valid with req_ready=0 is ignored; the requester must hold the request stable.
- Reset asserted in WAIT/RESP: the response is lost and the RAM is cleared. A store already committed at acceptance is also cleared by the RAM reset.

Optional Feature:
- Macro: DM_TRACE_EN.
- When defined: every committed, non-error store prints once at its acceptance edge, as
  `$display("%d@%h: *%h <= %h", $time, req_pc, {req_addr[31:2],2'b00}, merged_word)`
  where merged_word is the full 32-bit word after the lane merge.
- When undefined: no display statements; req_pc is unused. Functional behaviour is identical in both builds.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release -> req_ready=1 next cycle, resp_valid=0, all outputs 0.
- Word store/load, LATENCY=2:
  - SW addr 0x10 data 0xDEADBEEF accepted at T -> resp_valid at T+2, rdata=0, err=0.
  - LW addr 0x10 -> rdata 0xDEADBEEF two cycles after acceptance.
- Byte/half extension:
  - SB 0x80 to addr 0x13 over word 0x11223344 -> word 0x80223344.
  - LB addr 0x13 -> 0xFFFFFF80; LBU -> 0x00000080.
  - LH addr 0x12 -> 0xFFFF8022; LHU -> 0x00008022.
- Errors:
  - LW addr 0x2 -> err=1, rdata=0.
  - SW addr 0x4000 with ADDR_WIDTH=12 -> err=1 and word 0 unchanged.
  - req_op=6 -> err=1.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid and rdata stable, req_ready=0. Release -> IDLE next cycle; a second request is accepted one cycle later.
- Reset mid-WAIT: assert reset one cycle after an LW is accepted -> resp_valid never asserts, req_ready=0 until reset releases, and a following LW of that address returns 0.
